// File: rtl/seq_player_pkg.sv
// Shared types, width and sequence-length helper for seq_player_ctrl and its sub-blocks.
package seq_player_pkg;

    localparam int unsigned ADDR_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // A programmed length of zero stands for the full 2**ADDR_W block.
    function automatic logic [ADDR_W:0] eff_len(input logic [ADDR_W-1:0] len);
        return (len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, len};
    endfunction

endpackage

// File: rtl/seq_player_ctrl_tick_gen.sv
// Base-tick prescaler: one-cycle tick every TICK_DIV enabled clocks; holds count when disabled.
module tick_gen #(
    parameter int unsigned TICK_DIV = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = enable && (count == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_player_ctrl.sv
// Note-ROM sequencing controller with tempo, pause and single-step.
// Optional wrap-around playback enabled by defining SEQ_PLAYER_LOOP_EN.
module seq_player_ctrl
    import seq_player_pkg::*;
#(
    parameter int unsigned TICK_DIV = 5_000_000,
    parameter int unsigned ADDR_W   = seq_player_pkg::ADDR_W
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              start,
    input  logic              pause,
    input  logic              step,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] seq_len,
    input  logic [2:0]        tempo,
`ifdef SEQ_PLAYER_LOOP_EN
    input  logic              loop,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    output logic [ADDR_W-1:0] seq_num,
    output logic [2:0]        freq_num,
    output logic              note_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    state_t            state;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] seq_nxt;
    logic [2:0]        beat;
    logic              run_en;
    logic              tick;
    logic              beat_exp;
    logic              advance;
    logic              last_step;
    logic              wrap;

`ifdef SEQ_PLAYER_LOOP_EN
    assign wrap = loop;
`else
    assign wrap = 1'b0;
`endif

    assign run_en = (state == RUN);
    assign busy   = (state != IDLE);

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk    (CLOCK_50),
        .rst_n  (resetn),
        .enable (run_en),
        .clear  (start),
        .tick   (tick)
    );

    always_comb begin
        beat_exp  = tick && (beat == freq_num);
        advance   = beat_exp || ((state == PAUSE) && step);
        last_step = ({1'b0, seq_num} == (eff_len(len_q) - LEN_ONE));
        seq_nxt   = seq_num + ADDR_W'(1);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            base_addr  <= '0;
            len_q      <= '0;
            beat       <= '0;
            seq_num    <= '0;
            rom_addr   <= '0;
            freq_num   <= '0;
            note_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            note_valid <= 1'b0;
            done       <= 1'b0;
            if (start) begin
                base_addr  <= start_addr;
                len_q      <= seq_len;
                freq_num   <= tempo;
                beat       <= '0;
                seq_num    <= '0;
                rom_addr   <= start_addr;
                note_valid <= 1'b1;
                state      <= RUN;
            end else begin
                case (state)
                    RUN: begin
                        if (tick) beat <= beat_exp ? '0 : beat + 3'd1;
                        if (pause) state <= PAUSE;
                    end
                    PAUSE: begin
                        if (step) beat <= '0;
                        if (!pause) state <= RUN;
                    end
                    default: ;
                endcase
                // The advance must win over the RUN/PAUSE moves above at the last step.
                if (advance) begin
                    if (!last_step) begin
                        seq_num    <= seq_nxt;
                        rom_addr   <= base_addr + seq_nxt;
                        note_valid <= 1'b1;
                    end else if (wrap) begin
                        seq_num    <= '0;
                        rom_addr   <= base_addr;
                        note_valid <= 1'b1;
                        done       <= 1'b1;
                    end else begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: doc/seq_player_ctrl.md
# seq_player_ctrl

Sequencing controller for the sequence/frequency/ROM-address display datapath. Walks a contiguous block of the note ROM at a programmable tempo and drives `rom_addr`, `seq_num` (step index) and `freq_num` (tempo code) to the seven-segment display block and the ROM. Supports pause and manual single-step. Sits between the board-level key/switch conditioning and the display/ROM.

## Interface
Parameters:
- `TICK_DIV`, default 5_000_000: clocks per base tick; 0.1 s at 50 MHz. Legal range is ≥2.
- `ADDR_W`, default 7: ROM address, step and length width.

Ports:
- `CLOCK_50`, in, 1: sole clock; all logic on the rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle synchronous pulse; latches the configuration and begins playback.
- `pause`, in, 1: level; high freezes playback in RUN.
- `step`, in, 1: one-cycle pulse; advances one step while paused.
- `start_addr`, in, 7: first ROM address, latched on `start`.
- `seq_len`, in, 7: number of steps, latched on `start`; 0 means 128.
- `tempo`, in, 3: step period in ticks minus 1, latched on `start`.
- `loop`, in, 1: sampled at the last step; present only with `SEQ_PLAYER_LOOP_EN`.
- `rom_addr`, out, 7: `start_addr + seq_num`, modulo 128.
- `seq_num`, out, 7: current step index, 0-based.
- `freq_num`, out, 3: latched tempo code.
- `note_valid`, out, 1: one-cycle pulse when a new `rom_addr` is presented.
- `busy`, out, 1: high in RUN and PAUSE.
- `done`, out, 1: one-cycle pulse on sequence completion.

## Operation
States: IDLE, RUN, PAUSE.
- **IDLE:**
  - `start` latches `start_addr`, `seq_len` and `tempo`.
  - Clears the step counter and the tick prescaler.
  - Moves to RUN and asserts `note_valid` in the next cycle for step 0.
- **RUN:**
  - The prescaler counts `TICK_DIV` clocks per tick.
  - The beat counter counts `tempo+1` ticks.
  - On beat expiry: if `seq_num` is not the last step, increment it, pulse `note_valid`, and clear the beat counter.
  - On beat expiry at the last step (`seq_num == seq_len-1`, with `seq_len` 0 treated as 128): pulse `done` and go to IDLE.
  - `pause` high moves to PAUSE; the prescaler and beat counters hold their values.
- **PAUSE:**
  - `step` advances exactly as a beat expiry does, including the last-step rule, then clears the beat counter.
  - `pause` low returns to RUN, resuming the held counts.
- `start` while `busy` restarts from the newly latched configuration; this is legal in any state.
- Simultaneous events:
  - `start` beats everything else.
  - A `step` in RUN is ignored.
  - A beat expiry and `pause` rising in the same cycle: the advance happens, then the block enters PAUSE.
- `rom_addr` wraps modulo 128; no error is flagged.
- Outputs hold their last values in IDLE, so the display keeps the final step.

## Timing
- Reset values: `seq_num`=0, `rom_addr`=0, `freq_num`=0, `note_valid`=0, `done`=0, `busy`=0; state IDLE; all counters 0.
- `start` at cycle N: at N+1, `busy`=1, `note_valid`=1, `rom_addr`=`start_addr`, `seq_num`=0.
- Steady state: consecutive `note_valid` pulses are exactly `TICK_DIV*(tempo+1)` clocks apart.
- `step` at cycle N in PAUSE: the new `rom_addr` and `note_valid` appear at N+1.
- `done` and `busy`=0 appear in the cycle after the final beat expiry.
- `resetn` low mid-sequence: all outputs return to reset values immediately, asynchronously.

## Configuration
- `SEQ_PLAYER_LOOP_EN` defined:
  - The `loop` port exists.
  - At the last step, `loop`=1 wraps `seq_num` to 0, pulses `note_valid` and `done` together, and stays in RUN or PAUSE.
  - `loop`=0 ends the sequence as normal.
- Undefined: the `loop` port is absent and the sequence always ends in IDLE.

## Structure
- Package `seq_player_pkg` holds:
  - the state enum (IDLE, RUN, PAUSE);
  - `ADDR_W`;
  - the seq-length-zero-means-128 helper function.
- One sub-module, `tick_gen`: the prescaler with `enable` and `clear` inputs and a one-cycle `tick` output.

## Test plan
All scenarios use `TICK_DIV`=4.
- Reset, then idle for 100 cycles -> all outputs 0, no pulses.
- `start` with `start_addr`=10, `seq_len`=3, `tempo`=1 -> `note_valid` at cycles N+1, +9 and +17 with `rom_addr` 10, 11, 12; `done` at N+25; then `busy`=0.
- `start_addr`=126, `seq_len`=4, `tempo`=0 -> `rom_addr` sequence 126, 127, 0, 1.
- Pause after the first `note_valid` for 50 cycles, then pulse `step` twice -> `seq_num` goes 1, then 2, one cycle after each pulse, with no other advances.
- `start` during RUN at step 2 -> `seq_num`=0 in the next cycle with the new `rom_addr`; no `done` pulse.
- With `SEQ_PLAYER_LOOP_EN` defined and `loop`=1, `seq_len`=2 -> `seq_num` sequence 0, 1, 0, 1; `done` pulses at each wrap; `busy` stays 1.
